// File: rtl/stream_rr_distributor_pkg.sv
// Shared types for the stream round-robin distributor.
package stream_rr_distributor_pkg;

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_PRIO = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/stream_rr_distributor_rr_free_select.sv
// Picks the first free slot starting at the round-robin pointer (or at 0 in
// priority mode): rotate the free vector down by the pointer, then find its lowest set bit.
module rr_free_select
    import stream_rr_distributor_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     free_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  arb_mode_e        mode_i,
    output logic [IDX_W-1:0] sel_o,
    output logic             any_free_o
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [IDX_W-1:0] ptr;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] ofs;
    logic [IDX_W:0]   sum;

    always_comb begin
        ptr = (mode_i == ARB_PRIO) ? '0 : ptr_i;
        dbl = {free_i, free_i} >> ptr;
        rot = dbl[N-1:0];
        ofs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ofs = IDX_W'(i);
            end
        end
        // Wrap at N rather than 2**IDX_W so non-power-of-two slot counts work.
        sum   = {1'b0, ptr} + {1'b0, ofs};
        sel_o = (sum >= N_W) ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
    end

    assign any_free_o = |free_i;

endmodule

// File: rtl/stream_rr_distributor.sv
// Fans one valid-ready stream out over N_OUP single-entry output registers,
// choosing a free slot per beat round-robin or by fixed priority.
module stream_rr_distributor
    import stream_rr_distributor_pkg::*;
#(
    parameter type   DATA_T  = logic,
    parameter int    N_OUP   = -1,
    parameter string ARBITER = "rr",
    localparam int   IDX_W   = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  DATA_T                   inp_data_i,
    input  logic                    inp_valid_i,
    output logic                    inp_ready_o,
    output DATA_T [N_OUP-1:0]       oup_data_o,
    output logic  [N_OUP-1:0]       oup_valid_o,
    input  logic  [N_OUP-1:0]       oup_ready_i,
    output logic  [IDX_W-1:0]       oup_sel_o
);

    if (N_OUP < 2) begin : g_bad_n_oup
        $error("stream_rr_distributor: N_OUP must be at least 2");
    end
    if (ARBITER != "rr" && ARBITER != "prio") begin : g_bad_arbiter
        $error("stream_rr_distributor: ARBITER must be \"rr\" or \"prio\"");
    end

    localparam arb_mode_e MODE = (ARBITER == "prio") ? ARB_PRIO : ARB_RR;

    logic  [N_OUP-1:0] full_q, full_d;
    DATA_T [N_OUP-1:0] data_q, data_d;
    logic  [IDX_W-1:0] rr_q, rr_d;
    logic  [N_OUP-1:0] free;
    logic  [IDX_W-1:0] sel;
    logic              any_free;
    logic              accept;

    // A slot draining this cycle counts as free, giving one beat per cycle per slot.
    assign free = ~full_q | oup_ready_i;

    rr_free_select #(
        .N     (N_OUP),
        .IDX_W (IDX_W)
    ) u_select (
        .free_i     (free),
        .ptr_i      (rr_q),
        .mode_i     (MODE),
        .sel_o      (sel),
        .any_free_o (any_free)
    );

    assign inp_ready_o = any_free & ~flush_i;
    assign accept      = inp_valid_i & inp_ready_o;
    assign oup_sel_o   = sel;
    assign oup_valid_o = full_q;
    assign oup_data_o  = data_q;

    always_comb begin
        full_d = full_q & ~oup_ready_i;
        data_d = data_q;
        rr_d   = rr_q;
        if (accept) begin
            full_d[sel] = 1'b1;
            data_d[sel] = inp_data_i;
            if (MODE == ARB_RR) begin
                rr_d = (sel == IDX_W'(N_OUP - 1)) ? '0 : sel + IDX_W'(1);
            end
        end
        if (flush_i) begin
            full_d = '0;
            rr_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= '0;
            data_q <= '0;
            rr_q   <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            rr_q   <= rr_d;
        end
    end

endmodule

// File: tb/tb_stream_rr_distributor.sv
// Directed bench for stream_rr_distributor: three instances (4-slot rr, 3-slot rr,
// 4-slot prio) checked against a slot-tagged scoreboard.
module tb_stream_rr_distributor;

    typedef logic [7:0] byte_t;

    typedef struct {
        int    id;
        int    slot;
        byte_t data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b0;
    logic flush4 = 1'b0;
    logic no_flush = 1'b0;

    logic            v4 = 1'b0, r4;
    byte_t           d4 = '0;
    logic [1:0]      sel4;
    logic [3:0][7:0] od4;
    logic [3:0]      ov4;
    logic [3:0]      or4 = '0;

    logic            v3 = 1'b0, r3;
    byte_t           d3 = '0;
    logic [1:0]      sel3;
    logic [2:0][7:0] od3;
    logic [2:0]      ov3;
    logic [2:0]      or3 = '0;

    logic            vp = 1'b0, rp;
    byte_t           dp = '0;
    logic [1:0]      selp;
    logic [3:0][7:0] odp;
    logic [3:0]      ovp;
    logic [3:0]      orp = '0;

    stream_rr_distributor #(.DATA_T(byte_t), .N_OUP(4), .ARBITER("rr")) u_rr4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush4),
        .inp_data_i(d4), .inp_valid_i(v4), .inp_ready_o(r4),
        .oup_data_o(od4), .oup_valid_o(ov4), .oup_ready_i(or4), .oup_sel_o(sel4)
    );

    stream_rr_distributor #(.DATA_T(byte_t), .N_OUP(3), .ARBITER("rr")) u_rr3 (
        .clk_i(clk), .rst_i(rst), .flush_i(no_flush),
        .inp_data_i(d3), .inp_valid_i(v3), .inp_ready_o(r3),
        .oup_data_o(od3), .oup_valid_o(ov3), .oup_ready_i(or3), .oup_sel_o(sel3)
    );

    stream_rr_distributor #(.DATA_T(byte_t), .N_OUP(4), .ARBITER("prio")) u_prio (
        .clk_i(clk), .rst_i(rst), .flush_i(no_flush),
        .inp_data_i(dp), .inp_valid_i(vp), .inp_ready_o(rp),
        .oup_data_o(odp), .oup_valid_o(ovp), .oup_ready_i(orp), .oup_sel_o(selp)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_slot(input int id, input int slot, input byte_t data);
        int k;
        k = -1;
        for (int j = 0; j < sb.size(); j++) begin
            if (k < 0 && sb[j].id == id && sb[j].slot == slot) k = j;
        end
        chk($sformatf("sb_hit d%0d s%0d", id, slot), 32'(k >= 0), 32'd1);
        if (k >= 0) begin
            chk($sformatf("sb_data d%0d s%0d", id, slot), 32'(data), 32'(sb[k].data));
            sb.delete(k);
        end
    endtask

    task automatic monitor();
        for (int i = 0; i < 4; i++) if (ov4[i] && or4[i]) mon_slot(0, i, od4[i]);
        for (int i = 0; i < 3; i++) if (ov3[i] && or3[i]) mon_slot(1, i, od3[i]);
        for (int i = 0; i < 4; i++) if (ovp[i] && orp[i]) mon_slot(2, i, odp[i]);
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int id, input logic v, input byte_t d);
        case (id)
            0:       begin v4 = v; d4 = d; end
            1:       begin v3 = v; d3 = d; end
            default: begin vp = v; dp = d; end
        endcase
    endtask

    function automatic logic get_ready(input int id);
        case (id)
            0:       return r4;
            1:       return r3;
            default: return rp;
        endcase
    endfunction

    function automatic int get_sel(input int id);
        case (id)
            0:       return int'(sel4);
            1:       return int'(sel3);
            default: return int'(selp);
        endcase
    endfunction

    task automatic sb_flush(input int id);
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].id == id) sb.delete(j);
        end
    endtask

    task automatic send(input int id, input byte_t d, input int slot);
        set_in(id, 1'b1, d);
        #1;
        chk($sformatf("ready d%0d %0h", id, d), 32'(get_ready(id)), 32'd1);
        chk($sformatf("sel d%0d %0h", id, d), 32'(get_sel(id)), 32'(slot));
        sb.push_back('{id: id, slot: slot, data: d});
        cycle();
        set_in(id, 1'b0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_ov4", 32'(ov4), 32'd0);
        chk("rst_ov3", 32'(ov3), 32'd0);
        chk("rst_ovp", 32'(ovp), 32'd0);
        chk("rst_od4", 32'(od4), 32'd0);
        chk("rst_r4", 32'(r4), 32'd1);
        chk("rst_r3", 32'(r3), 32'd1);
        chk("rst_rp", 32'(rp), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // rr N=4, all ready: 8 back-to-back beats, one-cycle valid pulses
        or4 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            set_in(0, 1'b1, byte_t'(8'h10 + k));
            #1;
            chk($sformatf("b2b_ready %0d", k), 32'(r4), 32'd1);
            chk($sformatf("b2b_sel %0d", k), 32'(sel4), 32'(k % 4));
            chk($sformatf("b2b_ov %0d", k), 32'(ov4), (k == 0) ? 32'd0 : 32'(1 << ((k - 1) % 4)));
            sb.push_back('{id: 0, slot: k % 4, data: byte_t'(8'h10 + k)});
            cycle();
        end
        set_in(0, 1'b0, '0);
        #1;
        chk("b2b_ov_last", 32'(ov4), 32'h8);
        cycle();
        chk("b2b_ov_idle", 32'(ov4), 32'd0);

        // rr N=4, none ready: fill all slots, then refill slot 2 as it drains
        or4 = 4'b0000;
        send(0, 8'hA0, 0);
        send(0, 8'hA1, 1);
        send(0, 8'hA2, 2);
        send(0, 8'hA3, 3);
        set_in(0, 1'b1, 8'hA4);
        #1;
        chk("full_ready", 32'(r4), 32'd0);
        chk("full_ov", 32'(ov4), 32'hF);
        or4 = 4'b0100;
        #1;
        chk("refill_ready", 32'(r4), 32'd1);
        chk("refill_sel", 32'(sel4), 32'd2);
        sb.push_back('{id: 0, slot: 2, data: 8'hA4});
        cycle();
        set_in(0, 1'b0, '0);
        or4 = 4'b0000;
        #1;
        chk("refill_ov", 32'(ov4), 32'hF);
        chk("refill_data", 32'(od4[2]), 32'hA4);
        or4 = 4'b1111;
        cycle();
        or4 = 4'b0000;
        #1;
        chk("drain_ov", 32'(ov4), 32'd0);

        // Flush with slots 3 and 0 full and input valid
        send(0, 8'hB0, 3);
        send(0, 8'hB1, 0);
        chk("preflush_ov", 32'(ov4), 32'h9);
        set_in(0, 1'b1, 8'hB2);
        flush4 = 1'b1;
        #1;
        chk("flush_ready", 32'(r4), 32'd0);
        cycle();
        flush4 = 1'b0;
        set_in(0, 1'b0, '0);
        sb_flush(0);
        #1;
        chk("flush_ov", 32'(ov4), 32'd0);
        send(0, 8'hB3, 0);
        or4 = 4'b1111;
        cycle();
        or4 = 4'b0000;

        // rr N=3 with slot 1 stuck full: wraps 2 -> 0
        or3 = 3'b000;
        send(1, 8'hC0, 0);
        send(1, 8'hC1, 1);
        or3 = 3'b101;
        send(1, 8'hC2, 2);
        send(1, 8'hC3, 0);
        send(1, 8'hC4, 2);
        send(1, 8'hC5, 0);
        chk("n3_hold_valid", 32'(ov3[1]), 32'd1);
        chk("n3_hold_data", 32'(od3[1]), 32'hC1);
        or3 = 3'b111;
        cycle();
        or3 = 3'b000;
        #1;
        chk("n3_drain_ov", 32'(ov3), 32'd0);

        // prio N=4, slot 0 blocked
        orp = 4'b1110;
        send(2, 8'hD0, 0);
        send(2, 8'hD1, 1);
        send(2, 8'hD2, 1);
        orp = 4'b1111;
        cycle();
        orp = 4'b0000;
        #1;
        chk("prio_drain_ov", 32'(ovp), 32'd0);

        // Asynchronous reset while a beat is held
        send(2, 8'hE0, 0);
        chk("prio_held_ov", 32'(ovp), 32'd1);
        set_in(2, 1'b1, 8'hE1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ov", 32'(ovp), 32'd0);
        chk("midrst_od", 32'(odp), 32'd0);
        chk("midrst_ready", 32'(rp), 32'd1);
        sb_flush(2);
        set_in(2, 1'b0, '0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send(2, 8'hE2, 0);
        orp = 4'b1111;
        cycle();
        orp = 4'b0000;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
